// File: rtl/gray_pos_scheduler.sv
// Two-requester position scheduler: grants one move command at a time, steps a 3-bit position
// and publishes it Gray-coded. Define GPS_SHORTEST_PATH_EN to take the shorter direction (else always up).
module gray_pos_scheduler #(
  parameter int unsigned STEP_DIV = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [2:0] req0_target,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [2:0] req1_target,
  output logic       req1_ready,
  output logic [2:0] pos_gray,
  output logic       dir,
  output logic       busy,
  output logic       done,
  output logic       done_id
);

  typedef enum logic [1:0] {IDLE, MOVE, DONE} state_t;

  localparam logic [7:0] DIV_MAX = 8'(STEP_DIV - 1);

  state_t     state_q;
  logic [2:0] pos_q;
  logic [2:0] pos_gray_q;
  logic [2:0] target_q;
  logic [7:0] div_q;
  logic       dir_q;
  logic       id_q;
  logic       rr_q;

  logic       grant_valid;
  logic       grant_id;
  logic [2:0] grant_target;
  logic       grant_dir;
  logic [2:0] pos_step;

  always_comb begin
    grant_valid  = (state_q == IDLE) && (req0_valid || req1_valid);
    // Contention goes to the round-robin pointer; otherwise to whoever is asking.
    grant_id     = (req0_valid && req1_valid) ? rr_q : req1_valid;
    grant_target = grant_id ? req1_target : req0_target;
    pos_step     = dir_q ? 3'(pos_q + 3'd1) : 3'(pos_q - 3'd1);
  end

`ifdef GPS_SHORTEST_PATH_EN
  logic [2:0] grant_diff;
  assign grant_diff = 3'(grant_target - pos_q);
  assign grant_dir  = (grant_diff <= 3'd4);
`else
  assign grant_dir  = 1'b1;
`endif

  assign req0_ready = grant_valid && !grant_id;
  assign req1_ready = grant_valid && grant_id;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pos_q      <= 3'd0;
      pos_gray_q <= 3'd0;
      target_q   <= 3'd0;
      div_q      <= 8'd0;
      dir_q      <= 1'b1;
      id_q       <= 1'b0;
      rr_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            target_q <= grant_target;
            id_q     <= grant_id;
            dir_q    <= grant_dir;
            div_q    <= 8'd0;
            state_q  <= (grant_target != pos_q) ? MOVE : DONE;
          end
        end
        MOVE: begin
          if (div_q == DIV_MAX) begin
            div_q      <= 8'd0;
            pos_q      <= pos_step;
            pos_gray_q <= pos_step ^ (pos_step >> 1);
            if (pos_step == target_q) state_q <= DONE;
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
        DONE: begin
          rr_q    <= ~rr_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pos_gray = pos_gray_q;
  assign dir      = dir_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign done_id  = id_q;

endmodule

// File: doc/gray_pos_scheduler.md
GRAY_POS_SCHEDULER -- requirements
Module: gray_pos_scheduler

Interface
REQ-001 SHALL have parameter STEP_DIV, default 1, meaning clock cycles per counter step (legal range 1..255).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req0_valid  input  1  requester 0 has a move command.
REQ-005 SHALL have port req0_target  input  3  requester 0 target position (binary 0..7).
REQ-006 SHALL have port req0_ready  output  1  requester 0 command accepted this cycle.
REQ-007 SHALL have ports req1_valid / req1_target / req1_ready, identical to requester 0.
REQ-008 SHALL have port pos_gray  output  3  current position, Gray-coded (bin ^ bin>>1).
REQ-009 SHALL have port dir  output  1  active step direction, 1 = up, 0 = down.
REQ-010 SHALL have port busy  output  1  high in MOVE and DONE states.
REQ-011 SHALL have port done  output  1  one-cycle pulse on command completion.
REQ-012 SHALL have port done_id  output  1  requester index of the completed command, valid when done=1.

Function
REQ-013 SHALL implement FSM states IDLE, MOVE, DONE; internal position is a 3-bit binary register pos.
REQ-014 IDLE: if any req_valid, the grant SHALL be combinational: ready high for exactly one requester that cycle; latch target and id; next state MOVE if target != pos, else DONE.
REQ-015 Both valid in IDLE: the requester indicated by the round-robin pointer SHALL win; the other keeps valid high and is served next.
REQ-016 Round-robin pointer SHALL move to the other requester on each DONE, whichever requester was served.
REQ-017 req_ready SHALL be 0 in MOVE and DONE; requesters hold valid and target stable until ready.
REQ-018 Direction SHALL be fixed at grant: up if (target - pos) mod 8 <= 4, else down; distance 4 ties to up.
REQ-019 MOVE: a divider counts 0..STEP_DIV-1; on the edge where it equals STEP_DIV-1, pos SHALL step by +1/-1 mod 8 (7->0 up, 0->7 down) and the divider SHALL clear.
REQ-020 Divider SHALL clear on grant, so the first step occurs STEP_DIV cycles after the handshake edge.
REQ-021 When a step makes pos equal the target, next state SHALL be DONE.
REQ-022 DONE SHALL last one cycle with done=1 and done_id=latched id, then return to IDLE.
REQ-023 Latency, STEP_DIV=1, distance d: done SHALL be high d+1 cycles after the handshake cycle (d=0 -> next cycle).
REQ-024 pos_gray SHALL be a registered or glitch-free function of pos and SHALL change exactly one bit per step.
REQ-025 dir SHALL hold its value outside MOVE.

Reset
REQ-026 On reset: state=IDLE, pos=0, pos_gray=000, dir=1, busy=0, done=0, done_id=0, divider=0, round-robin pointer=requester 0.
REQ-027 Reset asserted mid-MOVE SHALL drop the command without a done pulse; the requester is not re-served unless it re-asserts valid.

Configuration
REQ-028 Macro GPS_SHORTEST_PATH_EN defined: direction per REQ-018.
REQ-029 Macro GPS_SHORTEST_PATH_EN undefined: dir is forced to 1, and every move counts up with wrap (distance = (target - pos) mod 8).

Verification
REQ-030 Reset, STEP_DIV=1, req0 target=3 -> ready0 on cycle 0; pos_gray 001, 011, 010; done=1, done_id=0 on cycle 4.
REQ-031 pos=1, req1 target=6 (distance 5) -> dir=0; pos 0, 7, 6; done on cycle 4 (with macro); without macro dir=1, 5 steps, done on cycle 6.
REQ-032 After reset, both valid, targets 2/5 -> req0 served first, req1 ready in the IDLE cycle after done, done_id sequence 0 then 1.
REQ-033 Valid with target == pos -> ready then done the next cycle, pos_gray unchanged, busy high for 1 cycle.
REQ-034 STEP_DIV=3, pos=0, target=2 -> steps at cycles 3 and 6, done on cycle 7.
REQ-035 Reset asserted during MOVE at pos=2 -> pos_gray=000 and state IDLE immediately, no done pulse.
